// File: rtl/load_issue_scheduler_pkg.sv
// Shared types for the load issue scheduler:
// FSM states, default widths and the queued load entry.
package ls_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ROB_W  = 6;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BCAST
   } ls_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [ROB_W-1:0]  rob;
   } load_entry_t;

endpackage

// File: rtl/load_issue_scheduler_if.sv
// Request, cache and CDB handshakes of the load issue scheduler.
// master = surrounding pipeline, slave = scheduler.
interface load_issue_scheduler_if #(
   parameter int ADDR_W = ls_pkg::ADDR_W,
   parameter int DATA_W = ls_pkg::DATA_W,
   parameter int ROB_W  = ls_pkg::ROB_W
);

   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic [ROB_W-1:0]  req_rob;
   logic              req_ready;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_hit;
   logic [DATA_W-1:0] mem_data;
   logic              cdb_req;
   logic              cdb_grant;
   logic [ROB_W-1:0]  cdb_rob;
   logic [DATA_W-1:0] cdb_data;

   modport master (
      output req_valid, req_addr, req_rob,
      output mem_hit, mem_data, cdb_grant,
      input  req_ready, mem_req, mem_addr,
      input  cdb_req, cdb_rob, cdb_data
   );

   modport slave (
      input  req_valid, req_addr, req_rob,
      input  mem_hit, mem_data, cdb_grant,
      output req_ready, mem_req, mem_addr,
      output cdb_req, cdb_rob, cdb_data
   );

endinterface

// File: rtl/load_issue_scheduler_fifo.sv
// Circular buffer of pending loads; head is
// exposed together with the entry behind it.
module load_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  head,
   output logic [W-1:0]  next,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] hd;
   logic [PW-1:0] tl;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         hd    <= '0;
         tl    <= '0;
         count <= '0;
      end else if (flush) begin
         hd    <= '0;
         tl    <= '0;
         count <= '0;
      end else begin
         if (push) tl <= tl + PW'(1);
         if (pop)  hd <= hd + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !flush) begin
         mem[tl] <= din;
      end
   end

   assign head  = mem[hd];
   assign next  = mem[hd + PW'(1)];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/load_issue_scheduler.sv
// In-order load issue: queue, single outstanding cache
// read, and hold of the result until the CDB grants.
module load_issue_scheduler
   import ls_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   rst_n,
   load_issue_scheduler_if.slave  bus,
   input  logic                   flush,
   output logic                   busy,
   output logic [CW-1:0]          count
);

   ls_state_e   state;
   load_entry_t din;
   load_entry_t head;
   load_entry_t next;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;

   assign din.addr      = bus.req_addr;
   assign din.rob       = bus.req_rob;
   assign bus.req_ready = !full;
   assign push = bus.req_valid && !full && !flush;
   assign pop  = (state == BCAST) && bus.cdb_grant && !flush;
   assign busy = !empty || (state != IDLE);

   load_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(load_entry_t))
   ) u_fifo (
      .clock (clock),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .head  (head),
      .next  (next),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         bus.mem_req  <= 1'b0;
         bus.mem_addr <= '0;
         bus.cdb_req  <= 1'b0;
         bus.cdb_rob  <= '0;
         bus.cdb_data <= '0;
      end else if (flush) begin
         state       <= IDLE;
         bus.mem_req <= 1'b0;
         bus.cdb_req <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!empty) begin
                  state        <= WAIT;
                  bus.mem_req  <= 1'b1;
                  bus.mem_addr <= head.addr;
               end
            end
            WAIT: begin
               if (bus.mem_hit) begin
                  state        <= BCAST;
                  bus.cdb_data <= bus.mem_data;
                  bus.cdb_rob  <= head.rob;
                  bus.mem_req  <= 1'b0;
                  bus.cdb_req  <= 1'b1;
               end
            end
            BCAST: begin
               if (bus.cdb_grant) begin
                  bus.cdb_req <= 1'b0;
                  // new head is the second entry, or the one
                  // being enqueued if the queue held only one
                  if (count > CW'(1)) begin
                     state        <= WAIT;
                     bus.mem_req  <= 1'b1;
                     bus.mem_addr <= next.addr;
                  end else if (push) begin
                     state        <= WAIT;
                     bus.mem_req  <= 1'b1;
                     bus.mem_addr <= din.addr;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_issue_scheduler.sv
// Directed scoreboard bench for load_issue_scheduler:
// stimulus queues expectations, a monitor checks the buses.
module tb_load_issue_scheduler;

   logic       clock = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       busy;
   logic [2:0] count;
   logic       hit_en;
   logic       hit_force;
   logic       grant_en;
   logic       mreq_prev;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] exp_addr[$];
   logic [37:0] exp_cdb[$];

   load_issue_scheduler_if bus ();

   load_issue_scheduler #(.DEPTH(4)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus),
      .flush (flush),
      .busy  (busy),
      .count (count)
   );

   always #5 clock = ~clock;

   // cache model: fixed word at 0x100, otherwise address-derived
   assign bus.mem_data  = (bus.mem_addr == 32'h100) ?
                          32'hDEAD_BEEF : (bus.mem_addr ^ 32'h5555_0000);
   assign bus.mem_hit   = hit_force | (hit_en & bus.mem_req);
   assign bus.cdb_grant = grant_en & bus.cdb_req;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic nx();
      @(posedge clock);
      #1;
   endtask

   task automatic enq(input logic [31:0] a,
                      input logic [5:0]  r,
                      input logic [31:0] d);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_rob   = r;
      exp_addr.push_back(a);
      exp_cdb.push_back({r, d});
      nx();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_cdb();
      for (int n = 0; n < 30; n++) begin
         if (bus.cdb_req) break;
         nx();
      end
      chk("cdb_req_wait", bus.cdb_req, 1);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 80; n++) begin
         if (!busy) break;
         nx();
      end
      chk("idle_wait", busy, 0);
   endtask

   task automatic clear_sb();
      exp_addr.delete();
      exp_cdb.delete();
   endtask

   // monitor: cache request addresses and CDB broadcasts
   always @(negedge clock) begin
      if (!rst_n) begin
         mreq_prev <= 1'b0;
      end else begin
         mreq_prev <= bus.mem_req;
         if (bus.mem_req && !mreq_prev) begin
            if (exp_addr.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL mem_unexp: got addr %0h expected none",
                        bus.mem_addr);
            end else begin
               chk("mem_addr", bus.mem_addr, exp_addr.pop_front());
            end
         end
         if (bus.cdb_req && bus.cdb_grant) begin
            if (exp_cdb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL cdb_unexp: got rob %0h expected none",
                        bus.cdb_rob);
            end else begin
               chk("cdb_bcast", {bus.cdb_rob, bus.cdb_data},
                   exp_cdb.pop_front());
            end
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      flush         = 1'b0;
      hit_en        = 1'b0;
      hit_force     = 1'b0;
      grant_en      = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_rob   = '0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_cdb_req", bus.cdb_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_cdb", {bus.cdb_rob, bus.cdb_data}, 0);
      #12;
      rst_n = 1'b1;
      #1;
      chk("rst_ready", bus.req_ready, 1);
      nx();

      // single load, zero-wait cache, immediate grant
      hit_en   = 1'b1;
      grant_en = 1'b1;
      enq(32'h100, 6'd5, 32'hDEAD_BEEF);
      chk("t1_count", count, 1);
      chk("t1_mreq0", bus.mem_req, 0);
      nx();
      chk("t1_mreq1", bus.mem_req, 1);
      chk("t1_maddr", bus.mem_addr, 32'h100);
      nx();
      chk("t1_mreq_off", bus.mem_req, 0);
      chk("t1_cdb_req", bus.cdb_req, 1);
      chk("t1_cdb_rob", bus.cdb_rob, 5);
      chk("t1_cdb_data", bus.cdb_data, 32'hDEAD_BEEF);
      nx();
      chk("t1_cdb_off", bus.cdb_req, 0);
      chk("t1_busy", busy, 0);
      nx();

      // fill to depth with a stalled cache
      hit_en   = 1'b0;
      grant_en = 1'b0;
      for (int i = 1; i <= 4; i++)
         enq(32'h200 + 32'(4 * i), 6'(i), 32'h5555_0200 + 32'(4 * i));
      chk("t2_full_cnt", count, 4);
      chk("t2_not_ready", bus.req_ready, 0);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h300;
      bus.req_rob   = 6'd7;
      nx();
      bus.req_valid = 1'b0;
      chk("t2_no_5th", count, 4);
      hit_en   = 1'b1;
      grant_en = 1'b1;
      nx();
      chk("t2_ready_bcast", bus.req_ready, 0);
      nx();
      chk("t2_ready_pop", bus.req_ready, 1);
      chk("t2_cnt_pop", count, 3);
      wait_idle();
      nx();

      // CDB backpressure
      hit_en   = 1'b1;
      grant_en = 1'b0;
      enq(32'h400, 6'd10, 32'h5555_0400);
      enq(32'h404, 6'd11, 32'h5555_0404);
      wait_cdb();
      for (int i = 0; i < 5; i++) begin
         chk("t3_cdb_req", bus.cdb_req, 1);
         chk("t3_cdb", {bus.cdb_rob, bus.cdb_data}, {6'd10, 32'h5555_0400});
         chk("t3_mreq", bus.mem_req, 0);
         chk("t3_count", count, 2);
         nx();
      end
      grant_en = 1'b1;
      nx();
      chk("t3_next_mreq", bus.mem_req, 1);
      chk("t3_next_addr", bus.mem_addr, 32'h404);
      chk("t3_count_pop", count, 1);
      wait_idle();
      nx();

      // flush while waiting on the cache
      hit_en   = 1'b0;
      grant_en = 1'b0;
      enq(32'h500, 6'd20, 32'h5555_0500);
      enq(32'h504, 6'd21, 32'h5555_0504);
      enq(32'h508, 6'd22, 32'h5555_0508);
      chk("t4_count", count, 3);
      chk("t4_mreq", bus.mem_req, 1);
      flush = 1'b1;
      nx();
      flush = 1'b0;
      clear_sb();
      chk("t4_fl_count", count, 0);
      chk("t4_fl_mreq", bus.mem_req, 0);
      chk("t4_fl_busy", busy, 0);
      hit_force = 1'b1;
      nx();
      hit_force = 1'b0;
      chk("t4_late_hit", bus.cdb_req, 0);
      chk("t4_late_busy", busy, 0);
      nx();
      chk("t4_quiet", {bus.cdb_req, bus.mem_req}, 0);

      // enqueue and grant on the same edge
      hit_en   = 1'b1;
      grant_en = 1'b0;
      enq(32'h600, 6'd30, 32'h5555_0600);
      enq(32'h604, 6'd31, 32'h5555_0604);
      wait_cdb();
      chk("t5_count", count, 2);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h608;
      bus.req_rob   = 6'd32;
      exp_addr.push_back(32'h608);
      exp_cdb.push_back({6'd32, 32'h5555_0608});
      grant_en = 1'b1;
      nx();
      bus.req_valid = 1'b0;
      chk("t5_count_same", count, 2);
      chk("t5_next_addr", bus.mem_addr, 32'h604);
      wait_idle();
      nx();

      // async reset in the middle of a broadcast
      hit_en   = 1'b1;
      grant_en = 1'b0;
      enq(32'h700, 6'd40, 32'h5555_0700);
      wait_cdb();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_cdb_req", bus.cdb_req, 0);
      chk("t6_mem_req", bus.mem_req, 0);
      chk("t6_count", count, 0);
      chk("t6_busy", busy, 0);
      chk("t6_cdb", {bus.cdb_rob, bus.cdb_data}, 0);
      clear_sb();
      hit_en = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      chk("t6_ready", bus.req_ready, 1);
      nx();
      nx();
      chk("t6_idle", {busy, bus.cdb_req, bus.mem_req}, 0);

      chk("sb_addr_left", exp_addr.size(), 0);
      chk("sb_cdb_left", exp_cdb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
